// File: rtl/uart_reg_dump.sv
// uart_reg_dump: periodically streams "Rn=XXXX\r\n" for eight 16-bit registers over an 8N1 UART.
module uart_reg_dump #(
  parameter int CLK_FREQ        = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int REPORT_INTERVAL = 27000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] regs [8],
  output logic        uart_tx,
  output logic        busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;
  typedef enum logic [1:0] {S_START, S_SEND, S_GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] reg_q, reg_d;
  logic [3:0] pos_q, pos_d;
  logic [GW-1:0] gap_q, gap_d;
  logic uart_tx_q, uart_tx_d, busy_q, busy_d;
  logic [15:0] snap_q [8];
  logic [15:0] snap_d [8];
  logic [15:0] word;
  logic [1:0] nib_sel;
  logic [3:0] nib;
  logic [7:0] hex, cur_byte;
  assign uart_tx = uart_tx_q;
  assign busy = busy_q;
  // Byte position 3..6 selects nibble 3..0 of the current register.
  always_comb begin
    word = snap_q[reg_q];
    nib_sel = 2'd2 - pos_q[1:0];
    nib = word[{nib_sel, 2'b00} +: 4];
    hex = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    cur_byte = (pos_q == 4'd0) ? 8'h52 :
               (pos_q == 4'd1) ? {5'b00110, reg_q} :
               (pos_q == 4'd2) ? 8'h3D :
               (pos_q == 4'd7) ? 8'h0D :
               (pos_q == 4'd8) ? 8'h0A : hex;
  end
  always_comb begin
    state_d = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_d = bit_q;
    reg_d = reg_q;
    pos_d = pos_q;
    gap_d = gap_q;
    uart_tx_d = uart_tx_q;
    busy_d = busy_q;
    snap_d = snap_q;
    case (state_q)
      S_START: begin
        snap_d = regs;
        reg_d = '0;
        pos_d = '0;
        bit_d = '0;
        clk_cnt_d = '0;
        uart_tx_d = 1'b0;
        busy_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (clk_cnt_q != CW'(CLKS_PER_BIT - 1)) clk_cnt_d = clk_cnt_q + CW'(1);
        else begin
          clk_cnt_d = '0;
          if (bit_q != 4'd9) begin
            bit_d = bit_q + 4'd1;
            uart_tx_d = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
          end else if (reg_q == 3'd7 && pos_q == 4'd8) begin
            uart_tx_d = 1'b1;
            busy_d = 1'b0;
            gap_d = GW'(REPORT_INTERVAL - 1);
            state_d = (REPORT_INTERVAL == 1) ? S_START : S_GAP;
          end else begin
            bit_d = '0;
            uart_tx_d = 1'b0;
            pos_d = (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd1;
            reg_d = (pos_q == 4'd8) ? reg_q + 3'd1 : reg_q;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        state_d = (gap_q == GW'(1)) ? S_START : S_GAP;
      end
      default: state_d = S_START;
    endcase
  end
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    if (rst) begin
      state_q <= S_START;
      clk_cnt_q <= '0;
      bit_q <= '0;
      reg_q <= '0;
      pos_q <= '0;
      gap_q <= '0;
      uart_tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_q <= bit_d;
      reg_q <= reg_d;
      pos_q <= pos_d;
      gap_q <= gap_d;
      uart_tx_q <= uart_tx_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_reg_dump.sv
// tb_uart_reg_dump: checks framing, dump text, snapshot, interval and reset of uart_reg_dump.
module tb_uart_reg_dump;
  localparam int C = 4;
  localparam int BYTE = 10 * C;
  localparam int DUMP = 72 * BYTE;
  localparam int PER = DUMP + 10;
  localparam int WIN = 3 * PER + 30 * BYTE + 3 * C + 1;
  typedef struct {int cyc; logic tx; logic busy;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] regs [8];
  logic uart_tx, busy;
  int vectors = 0;
  int miscompares = 0;
  logic tx_log [WIN];
  logic busy_log [WIN];
  logic [15:0] snaps [4][8];
  vec_t tab [18];
  uart_reg_dump #(.CLK_FREQ(4), .BAUD_RATE(1), .REPORT_INTERVAL(10)) dut (
    .clk(clk), .rst(rst), .regs(regs), .uart_tx(uart_tx), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction
  // Expected text byte k of dump d, derived from the "Rn=XXXX\r\n" layout.
  function automatic logic [7:0] exp_byte(input int d, input int k);
    int r = k / 9;
    int p = k % 9;
    logic [15:0] v = snaps[d][r];
    case (p)
      0: return 8'h52;
      1: return 8'h30 + r[7:0];
      2: return 8'h3D;
      7: return 8'h0D;
      8: return 8'h0A;
      default: return hexc(v[(6 - p) * 4 +: 4]);
    endcase
  endfunction
  function automatic logic exp_tx(input int n);
    int d = n / PER;
    int off = n % PER;
    int b;
    logic [7:0] c;
    if (off >= DUMP) return 1'b1;
    c = exp_byte(d, off / BYTE);
    b = (off % BYTE) / C;
    return (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : c[b - 1];
  endfunction
  function automatic logic [7:0] decode(input int base, input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = tx_log[base + k * BYTE + (j + 1) * C + 2];
    return v;
  endfunction
  task automatic run_window(input int n);
    snaps[0] = regs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i] = uart_tx;
      busy_log[i] = busy;
      if (i == 20 * BYTE + 5) begin
        regs[0] = 16'h1234;
        regs[3] = 16'hBEEF;
        regs[5] = 16'hA0F9;
      end
      if (i > PER && $urandom_range(0, 63) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
      if ((i + 1) % PER == 0 && (i + 1) / PER < 4) snaps[(i + 1) / PER] = regs;
    end
  endtask
  task automatic check_window(input int n);
    for (int i = 0; i < n; i++) begin
      chk("tx_model", i, {7'd0, tx_log[i]}, {7'd0, exp_tx(i)});
      chk("busy_model", i, {7'd0, busy_log[i]}, {7'd0, ((i % PER) < DUMP)});
    end
  endtask
  initial begin
    string sa, s3, s5, s0;
    logic [9:0] frame;
    sa = "R0=0001\r\nR1=0002\r\nR2=0003\r\nR3=0004\r\nR4=0005\r\nR5=0006\r\nR6=0007\r\nR7=0008\r\n";
    s0 = "R0=1234";
    s3 = "R3=BEEF\r\n";
    s5 = "R5=A0F9\r\n";
    frame = 10'b1010100100;
    for (int k = 0; k < 10; k++) tab[k] = '{4 * k + 2, frame[k], 1'b1};
    tab[10] = '{0, 1'b0, 1'b1};
    tab[11] = '{7, 1'b0, 1'b1};
    tab[12] = '{8, 1'b1, 1'b1};
    tab[13] = '{DUMP - 1, 1'b1, 1'b1};
    tab[14] = '{DUMP, 1'b1, 1'b0};
    tab[15] = '{PER - 1, 1'b1, 1'b0};
    tab[16] = '{PER, 1'b0, 1'b1};
    tab[17] = '{PER + 4, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) regs[i] = 16'(i + 1);
    repeat (5) begin
      @(negedge clk);
      chk("reset_tx", 0, {7'd0, uart_tx}, 8'd1);
      chk("reset_busy", 0, {7'd0, busy}, 8'd0);
    end
    rst = 1'b0;
    run_window(WIN);
    for (int t = 0; t < 18; t++) begin
      chk("tab_tx", tab[t].cyc, {7'd0, tx_log[tab[t].cyc]}, {7'd0, tab[t].tx});
      chk("tab_busy", tab[t].cyc, {7'd0, busy_log[tab[t].cyc]}, {7'd0, tab[t].busy});
    end
    for (int k = 0; k < 72; k++) chk("dumpA_text", k, decode(0, k), sa[k]);
    for (int k = 0; k < 7; k++) chk("dumpB_R0", k, decode(PER, k), s0[k]);
    for (int k = 0; k < 9; k++) chk("dumpB_R3", k, decode(PER, 27 + k), s3[k]);
    for (int k = 0; k < 9; k++) chk("dumpB_R5", k, decode(PER, 45 + k), s5[k]);
    check_window(WIN);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_tx", 0, {7'd0, uart_tx}, 8'd1);
    chk("midreset_busy", 0, {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run_window(3 * BYTE);
    chk("restart_b0", 0, decode(0, 0), 8'h52);
    chk("restart_b1", 1, decode(0, 1), 8'h30);
    check_window(3 * BYTE);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
